// File: rtl/qdot_pkg.sv
// Shared types and width helpers for the fixed-point dot-product sequencer.
package qdot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        ROUND,
        DONE
    } state_t;

    function automatic int unsigned op_w(input int unsigned nfb);
        return nfb + 1;
    endfunction

    function automatic int unsigned acc_w(input int unsigned nfb, input int unsigned max_len);
        return 2 * (nfb + 1) + $clog2(max_len);
    endfunction

    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // Half an output LSB, added before the truncating shift
    function automatic int unsigned round_off(input int unsigned nfb);
        return 32'd1 << (nfb - 1);
    endfunction

endpackage

// File: rtl/qdot_if.sv
// Control, operand-stream and result-stream signals of the dot-product sequencer.
interface qdot_if
    import qdot_pkg::*;
#(
    parameter int unsigned NUM_FIXED_BITS = 8,
    parameter int unsigned MAX_LEN        = 16
) ();
    localparam int unsigned W     = op_w(NUM_FIXED_BITS);
    localparam int unsigned LEN_W = len_w(MAX_LEN);

    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    busy;
    logic signed [W-1:0]     a_data;
    logic signed [W-1:0]     b_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     res_data;
    logic                    res_sat;
    logic                    res_valid;
    logic                    res_ready;

    modport master (
        output start, len, a_data, b_data, in_valid, res_ready,
        input  busy, in_ready, res_data, res_sat, res_valid
    );

    modport slave (
        input  start, len, a_data, b_data, in_valid, res_ready,
        output busy, in_ready, res_data, res_sat, res_valid
    );
endinterface

// File: rtl/qmul.sv
// Registered signed W x W -> 2W multiplier; the single shared multiply resource.
module qmul
    import qdot_pkg::*;
#(
    parameter int unsigned W = op_w(8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic                  out_valid,
    output logic signed [2*W-1:0] p
);
    localparam int unsigned PW = 2 * W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            p         <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                p <= PW'(a) * PW'(b);
            end
        end
    end
endmodule

// File: rtl/qdot_sequencer.sv
// Dot product of up to MAX_LEN signed Q0.N pairs through one shared registered
// multiplier and a guard-bit accumulator; result is rounded and saturated.
module qdot_sequencer
    import qdot_pkg::*;
#(
    parameter int unsigned NUM_FIXED_BITS = 8,
    parameter int unsigned MAX_LEN        = 16
) (
    input  logic  clk,
    input  logic  rst,
    qdot_if.slave bus
);
    localparam int unsigned W     = op_w(NUM_FIXED_BITS);
    localparam int unsigned ACC_W = acc_w(NUM_FIXED_BITS, MAX_LEN);
    localparam int unsigned LEN_W = len_w(MAX_LEN);
    localparam int unsigned PW    = 2 * W;
    localparam int unsigned RW    = ACC_W - NUM_FIXED_BITS;

    localparam logic [LEN_W-1:0]        MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic signed [ACC_W-1:0] RND       = ACC_W'(round_off(NUM_FIXED_BITS));
    localparam int                      SAT_HI    = (1 << NUM_FIXED_BITS) - 1;
    localparam int                      SAT_LO    = -(1 << NUM_FIXED_BITS);

    state_t                   state, state_n;
    logic [LEN_W-1:0]         count;
    logic signed [ACC_W-1:0]  acc;
    logic                     p_valid;
    logic signed [PW-1:0]     prod;

    logic                     busy_q, in_ready_q, res_valid_q, res_sat_q;
    logic signed [W-1:0]      res_data_q;

    logic                     accept_c;
    logic [LEN_W-1:0]         len_clamped_c;
    logic signed [ACC_W-1:0]  rsum_c;
    logic signed [RW-1:0]     r_c;
    logic signed [W-1:0]      sat_data_c;
    logic                     sat_flag_c;

    assign accept_c      = bus.in_valid & in_ready_q & (state == RUN);
    assign len_clamped_c = (bus.len > MAX_LEN_V) ? MAX_LEN_V : bus.len;

    qmul #(.W(W)) u_qmul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept_c),
        .a         (bus.a_data),
        .b         (bus.b_data),
        .out_valid (p_valid),
        .p         (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = (bus.len == '0) ? ROUND : RUN;
            RUN:     if (accept_c && count == LEN_W'(1)) state_n = DRAIN;
            DRAIN:   state_n = ROUND;
            ROUND:   state_n = DONE;
            DONE:    if (bus.res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Round half toward +inf, then clip to the operand range
    always_comb begin
        rsum_c     = acc + RND;
        r_c        = RW'(rsum_c >>> NUM_FIXED_BITS);
        sat_flag_c = 1'b0;
        sat_data_c = W'(r_c);
        if (r_c > RW'(SAT_HI)) begin
            sat_flag_c = 1'b1;
            sat_data_c = W'(SAT_HI);
        end else if (r_c < RW'(SAT_LO)) begin
            sat_flag_c = 1'b1;
            sat_data_c = W'(SAT_LO);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            acc         <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_sat_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            busy_q      <= (state_n != IDLE);
            in_ready_q  <= (state_n == RUN);
            res_valid_q <= (state_n == DONE);
            if (state == IDLE && bus.start) begin
                count <= len_clamped_c;
                acc   <= '0;
            end else begin
                if (accept_c) count <= count - LEN_W'(1);
                if (p_valid)  acc   <= acc + ACC_W'(prod);
            end
            if (state == ROUND) begin
                res_data_q <= sat_data_c;
                res_sat_q  <= sat_flag_c;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sat   = res_sat_q;
    assign bus.res_data  = res_data_q;
endmodule

// File: tb/tb_qdot_sequencer.sv
// Scoreboard bench for qdot_sequencer: expected results queued at stimulus time.
module tb_qdot_sequencer;
    typedef struct {
        int data;
        bit sat;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   hs_cnt;
    int   rdy_cnt;
    int   va [0:31];
    int   vb [0:31];
    exp_t sb [$];

    qdot_if #(.NUM_FIXED_BITS(8), .MAX_LEN(16)) bus ();

    qdot_sequencer #(.NUM_FIXED_BITS(8), .MAX_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake and in_ready observers (pre-edge values)
    always @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) hs_cnt <= hs_cnt + 1;
        if (bus.in_ready) rdy_cnt <= rdy_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_op(input int L, input int gap, input int hold);
        int      eff;
        int      idx;
        int      budget;
        int      c;
        int      snap;
        longint  s;
        longint  r;
        exp_t    e;
        exp_t    got;
        bit      v;
        eff = (L > 16) ? 16 : L;
        s = 0;
        for (int i = 0; i < eff; i++) s += longint'(va[i]) * longint'(vb[i]);
        r = (s + 128) >>> 8;
        e.sat = 1'b0;
        if (r > 255) begin
            r = 255; e.sat = 1'b1;
        end else if (r < -256) begin
            r = -256; e.sat = 1'b1;
        end
        e.data = int'(r);
        sb.push_back(e);
        snap = hs_cnt;

        @(negedge clk); bus.start = 1'b1; bus.len = 5'(L);
        @(negedge clk); bus.start = 1'b0;
        idx = 0;
        budget = 400;
        while (idx < eff && budget > 0) begin
            v = (gap == 0) || (int'($urandom_range(0, 99)) >= gap);
            bus.in_valid = v;
            bus.a_data = 9'(va[idx]);
            bus.b_data = 9'(vb[idx]);
            if (v && bus.in_ready) idx++;
            budget--;
            @(negedge clk);
        end
        if (idx < eff) begin
            tests++; fails++;
            $display("FAIL feed_timeout: accepted %0d, required %0d", idx, eff);
        end
        // Offer an extra pair that must not be taken
        bus.in_valid = 1'b1;
        if (eff > 0) begin
            tests++;
            if (bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL in_ready_drop: got %b, expected 0", bus.in_ready);
            end
        end
        c = 1;
        while (bus.res_valid !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        bus.in_valid = 1'b0;
        tests++;
        if (bus.res_valid !== 1'b1) begin
            fails++;
            $display("FAIL res_valid_timeout: got %b, expected 1", bus.res_valid);
        end
        if (eff > 0) begin
            tests++;
            if (c !== 3) begin
                fails++;
                $display("FAIL latency: res_valid at edge %0d, expected 3", c);
            end
        end
        got = sb.pop_front();
        tests++;
        if (int'(bus.res_data) !== got.data) begin
            fails++;
            $display("FAIL res_data(len=%0d): got %0d, expected %0d", L, bus.res_data, got.data);
        end
        tests++;
        if (bus.res_sat !== got.sat) begin
            fails++;
            $display("FAIL res_sat(len=%0d): got %b, expected %b", L, bus.res_sat, got.sat);
        end
        for (int i = 0; i < hold; i++) begin
            bus.start = (i % 3 == 0);
            bus.len = 5'd1;
            @(negedge clk);
            tests++;
            if (bus.res_valid !== 1'b1 || int'(bus.res_data) !== got.data || bus.res_sat !== got.sat) begin
                fails++;
                $display("FAIL hold_stable[%0d]: valid %b data %0d sat %b, expected 1 %0d %b",
                         i, bus.res_valid, bus.res_data, bus.res_sat, got.data, got.sat);
            end
        end
        bus.res_ready = 1'b1;
        bus.start = (hold > 0);
        bus.len = 5'd1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.start = 1'b0;
        tests++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL release: res_valid %b busy %b, expected 0 0", bus.res_valid, bus.busy);
        end
        tests++;
        if (hs_cnt - snap !== eff) begin
            fails++;
            $display("FAIL consumed(len=%0d): got %0d, expected %0d", L, hs_cnt - snap, eff);
        end
    endtask

    task automatic test_reset();
        tests++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.res_sat !== 1'b0 || bus.res_data !== 9'sd0) begin
            fails++;
            $display("FAIL reset_state: busy %b rdy %b valid %b sat %b data %0d, expected all 0",
                     bus.busy, bus.in_ready, bus.res_valid, bus.res_sat, bus.res_data);
        end
    endtask

    task automatic test_single_pair();
        va[0] = 128; vb[0] = 128;
        run_op(1, 0, 0);
    endtask

    task automatic test_rounding();
        va[0] = 1;    vb[0] = 128; run_op(1, 0, 0);
        va[0] = 1;    vb[0] = 127; run_op(1, 0, 0);
        va[0] = -256; vb[0] = 255; run_op(1, 0, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin va[i] = 128; vb[i] = 128; end
        run_op(4, 0, 0);
        for (int i = 0; i < 4; i++) begin va[i] = -256; vb[i] = 255; end
        run_op(4, 0, 0);
    endtask

    task automatic test_stress();
        for (int i = 0; i < 16; i++) begin
            va[i] = int'($urandom_range(0, 511)) - 256;
            vb[i] = int'($urandom_range(0, 511)) - 256;
        end
        run_op(16, 40, 10);
        for (int i = 0; i < 16; i++) begin
            va[i] = int'($urandom_range(0, 127));
            vb[i] = int'($urandom_range(0, 63)) - 32;
        end
        run_op(16, 60, 3);
    endtask

    task automatic test_len_edges();
        int snap;
        snap = rdy_cnt;
        run_op(0, 0, 2);
        tests++;
        if (rdy_cnt - snap !== 0) begin
            fails++;
            $display("FAIL len0_in_ready: %0d ready cycles, expected 0", rdy_cnt - snap);
        end
        for (int i = 0; i < 32; i++) begin
            va[i] = 100 + i;
            vb[i] = (i % 2 == 0) ? 7 : -3;
        end
        run_op(31, 20, 0);
    endtask

    task automatic test_reset_mid_run();
        int snap;
        snap = hs_cnt;
        @(negedge clk); bus.start = 1'b1; bus.len = 5'd8;
        @(negedge clk); bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a_data = 9'(50 + i);
            bus.b_data = 9'(60 - i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        tests++;
        if (hs_cnt - snap !== 5) begin
            fails++;
            $display("FAIL pre_reset_accepts: got %0d, expected 5", hs_cnt - snap);
        end
        #2 rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: valid %b busy %b, expected 0 0", bus.res_valid, bus.busy);
        end
        va[0] = 64; vb[0] = 64; va[1] = 64; vb[1] = 64;
        run_op(2, 0, 0);
    endtask

    initial begin
        tests = 0; fails = 0; hs_cnt = 0; rdy_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.len = '0;
        bus.a_data = '0; bus.b_data = '0;
        bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_pair();
        test_rounding();
        test_saturation();
        test_stress();
        test_len_edges();
        test_reset_mid_run();
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
